// File: rtl/serial_sub.sv
// serial_sub: bit-serial x - y - bin, LSB first, one full-subtractor cell behind valid/ready.
// Define SERIAL_SUB_FLAGS_EN to add registered ovf/zero flag outputs.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             bout,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             ovf,
    output logic             zero,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] xs, ys, res, res_nxt;
    logic [CW-1:0]    cnt;
    logic             br, d, bo, last;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             xm, ym;
`endif

    assign d       = xs[0] ^ ys[0] ^ br;
    assign bo      = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & br);
    assign res_nxt = {d, res[WIDTH-1:1]};
    assign last    = cnt == CW'(WIDTH - 1);

    always_comb begin
        nxt       = state;
        in_ready  = state == IDLE;
        busy      = state == RUN;
        out_valid = state == DONE;
        nxt = (state == IDLE && in_valid)  ? RUN  :
              (state == RUN  && last)      ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            f     <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            xm    <= 1'b0;
            ym    <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == IDLE && in_valid) begin
                xs  <= x;
                ys  <= y;
                br  <= bin;
                res <= '0;
                cnt <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
                // operand sign bits are shifted out by the end, so keep them for ovf
                xm  <= x[WIDTH-1];
                ym  <= y[WIDTH-1];
`endif
            end else if (state == RUN) begin
                xs  <= xs >> 1;
                ys  <= ys >> 1;
                res <= res_nxt;
                br  <= bo;
                cnt <= cnt + 1'b1;
                if (last) begin
                    f    <= res_nxt;
                    bout <= bo;
`ifdef SERIAL_SUB_FLAGS_EN
                    ovf  <= (xm != ym) && (d != xm);
                    zero <= res_nxt == '0;
`endif
                end
            end
        end
    end
endmodule
